vmem_leak_engine: RTL and testbench

VMEM_LEAK_ENGINE -- requirements
Module: vmem_leak_engine

---
 rtl/vmem_leak_engine_if.sv | 38 +++
 rtl/vmem_leak_engine.sv | 211 +++++++++++++++++++++
 tb/tb_vmem_leak_engine.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/vmem_leak_engine_if.sv
// Request/result handshake bundle for the membrane leak engine.
// master: request producer / result consumer; slave: the engine.
interface vmem_leak_engine_if #(
    parameter int INTEGER_WIDTH   = 32,
    parameter int DATA_WIDTH_FRAC = 32,
    parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int DELTAT_WIDTH    = 4,
    parameter int TAG_WIDTH       = 8
);
    logic                     InValid;
    logic                     InReady;
    logic [INTEGER_WIDTH-1:0] Vrest;
    logic [DATA_WIDTH-1:0]    Vmem;
    logic [DELTAT_WIDTH-1:0]  DeltaT;
    logic [INTEGER_WIDTH-1:0] Taumem;
    logic                     ShiftMode;
    logic [TAG_WIDTH-1:0]     InTag;
    logic                     OutValid;
    logic                     OutReady;
    logic [DATA_WIDTH-1:0]    VmemOut;
    logic [TAG_WIDTH-1:0]     OutTag;
    logic                     DivZero;
    logic                     Sat;

    modport master (
        output InValid, Vrest, Vmem, DeltaT, Taumem,
        output ShiftMode, InTag, OutReady,
        input  InReady, OutValid, VmemOut, OutTag,
        input  DivZero, Sat
    );

    modport slave (
        input  InValid, Vrest, Vmem, DeltaT, Taumem,
        input  ShiftMode, InTag, OutReady,
        output InReady, OutValid, VmemOut, OutTag,
        output DivZero, Sat
    );
endinterface

// File: rtl/vmem_leak_engine.sv
// Membrane leak: Vout = Vmem + ((Vrest - Vmem) * DeltaT) / Taumem.
// Ports: clk_i, rst_i (async, active high), bus (slave handshake bundle).
module vmem_leak_engine #(
    parameter int INTEGER_WIDTH   = 32,
    parameter int DATA_WIDTH_FRAC = 32,
    parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int DELTAT_WIDTH    = 4,
    parameter int TAG_WIDTH       = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    vmem_leak_engine_if.slave   bus
);
    localparam int IW = INTEGER_WIDTH;
    localparam int FW = DATA_WIDTH_FRAC;
    localparam int DW = DATA_WIDTH;
    localparam int TW = DELTAT_WIDTH;
    localparam int GW = TAG_WIDTH;
    localparam int SW = $clog2(DW);

    localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic [SW-1:0] CNT_LAST = SW'(DW - 1);

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        ADD,
        DONE
    } state_t;

    state_t        state_q;
    logic [IW-1:0] vrest_q;
    logic [DW-1:0] vmem_q;
    logic [TW-1:0] dt_q;
    logic [IW-1:0] tau_q;
    logic          mode_q;
    logic [GW-1:0] tag_q;
    logic [DW-1:0] q_q;
    logic          q_neg_q;
    logic [DW-1:0] quo_q;
    logic [DW-1:0] rem_q;
    logic [DW-1:0] dvs_q;
    logic [SW-1:0] cnt_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [DW-1:0] vmem_out_q;
    logic [GW-1:0] out_tag_q;
    logic          div_zero_q;
    logic          sat_q;

    logic [DW:0]    v1_wide;
    logic           v1_ovf;
    logic [DW-1:0]  v1_sat;
    logic [DW+TW:0] prod;
    logic [DW-1:0]  m_d;
    logic [SW-1:0]  shamt;
    logic [DW-1:0]  m_shift_d;
    logic [DW-1:0]  m_abs_d;
    logic [IW-1:0]  tau_abs;
    logic [DW-1:0]  dvs_d;
    logic [DW:0]    rem_sh;
    logic [DW:0]    diff;
    logic           no_borrow;
    logic [DW-1:0]  rem_d;
    logic [DW-1:0]  quo_d;
    logic [DW-1:0]  q_div_d;
    logic [DW:0]    sum_wide;
    logic           sum_ovf;
    logic [DW-1:0]  sum_sat_d;
    logic           unused_prod;

    always_comb begin
        // Difference to rest, one guard bit, then clamp.
        v1_wide = {vrest_q[IW-1], vrest_q, {FW{1'b0}}}
                - {vmem_q[DW-1], vmem_q};
        v1_ovf  = v1_wide[DW] ^ v1_wide[DW-1];
        v1_sat  = v1_wide[DW-1:0];
        if (v1_ovf) begin
            v1_sat = v1_wide[DW] ? SMIN : SMAX;
        end

        // DeltaT is a pure fraction: multiply, then drop its TW bits.
        // Operands are widened so the modular product is the signed one.
        prod = {{(TW+1){v1_sat[DW-1]}}, v1_sat}
             * {{(DW+1){1'b0}}, dt_q};
        m_d  = prod[DW+TW-1:TW];

        shamt = tau_q[SW-1:0];
        if (tau_q > IW'(DW - 1)) begin
            shamt = CNT_LAST;
        end
        m_shift_d = $signed(m_d) >>> shamt;

        // Divider works on magnitudes; sign is restored at the end.
        m_abs_d = m_d[DW-1] ? -m_d : m_d;
        tau_abs = tau_q[IW-1] ? -tau_q : tau_q;
        dvs_d   = DW'(tau_abs);

        rem_sh    = {rem_q, quo_q[DW-1]};
        diff      = rem_sh - {1'b0, dvs_q};
        no_borrow = ~diff[DW];
        rem_d     = no_borrow ? diff[DW-1:0] : rem_sh[DW-1:0];
        quo_d     = {quo_q[DW-2:0], no_borrow};
        q_div_d   = q_neg_q ? -quo_d : quo_d;

        sum_wide  = {vmem_q[DW-1], vmem_q} + {q_q[DW-1], q_q};
        sum_ovf   = sum_wide[DW] ^ sum_wide[DW-1];
        sum_sat_d = sum_wide[DW-1:0];
        if (sum_ovf) begin
            sum_sat_d = sum_wide[DW] ? SMIN : SMAX;
        end
    end

    assign unused_prod = ^{prod[DW+TW], prod[TW-1:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            vrest_q     <= '0;
            vmem_q      <= '0;
            dt_q        <= '0;
            tau_q       <= '0;
            mode_q      <= 1'b0;
            tag_q       <= '0;
            q_q         <= '0;
            q_neg_q     <= 1'b0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            vmem_out_q  <= '0;
            out_tag_q   <= '0;
            div_zero_q  <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.InValid && in_ready_q) begin
                        vrest_q    <= bus.Vrest;
                        vmem_q     <= bus.Vmem;
                        dt_q       <= bus.DeltaT;
                        tau_q      <= bus.Taumem;
                        mode_q     <= bus.ShiftMode;
                        tag_q      <= bus.InTag;
                        div_zero_q <= 1'b0;
                        sat_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= MULT;
                    end
                end
                MULT: begin
                    sat_q   <= v1_ovf;
                    q_neg_q <= m_d[DW-1] ^ tau_q[IW-1];
                    quo_q   <= m_abs_d;
                    rem_q   <= '0;
                    dvs_q   <= dvs_d;
                    cnt_q   <= '0;
                    if (mode_q) begin
                        q_q     <= m_shift_d;
                        state_q <= ADD;
                    end else if (tau_q == '0) begin
                        q_q        <= '0;
                        div_zero_q <= 1'b1;
                        state_q    <= ADD;
                    end else begin
                        state_q <= DIV;
                    end
                end
                DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        q_q     <= q_div_d;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    vmem_out_q  <= sum_sat_d;
                    sat_q       <= sat_q | sum_ovf;
                    out_tag_q   <= tag_q;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (bus.OutReady) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.InReady  = in_ready_q;
    assign bus.OutValid = out_valid_q;
    assign bus.VmemOut  = vmem_out_q;
    assign bus.OutTag   = out_tag_q;
    assign bus.DivZero  = div_zero_q;
    assign bus.Sat      = sat_q;
endmodule

// File: tb/tb_vmem_leak_engine.sv
// Directed-vector bench for vmem_leak_engine.
// Table of hand-computed results plus backpressure and reset sequences.
module tb_vmem_leak_engine;
    typedef struct {
        logic [31:0] vrest;
        logic [63:0] vmem;
        logic [3:0]  dt;
        logic [31:0] tau;
        logic        mode;
        logic [7:0]  tag;
        logic [63:0] exp_out;
        logic        exp_dz;
        logic        exp_sat;
        int          exp_lat;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    vec_t vecs[10];

    vmem_leak_engine_if #(
        .INTEGER_WIDTH(32),
        .DATA_WIDTH_FRAC(32),
        .DELTAT_WIDTH(4),
        .TAG_WIDTH(8)
    ) bus ();

    vmem_leak_engine #(
        .INTEGER_WIDTH(32),
        .DATA_WIDTH_FRAC(32),
        .DELTAT_WIDTH(4),
        .TAG_WIDTH(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic issue(input vec_t v, output int lat);
        int w;
        w = 0;
        while (bus.InReady !== 1'b1 && w < 10) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("accept_ready", 64'(bus.InReady), 64'd1);
        bus.Vrest     = v.vrest;
        bus.Vmem      = v.vmem;
        bus.DeltaT    = v.dt;
        bus.Taumem    = v.tau;
        bus.ShiftMode = v.mode;
        bus.InTag     = v.tag;
        bus.InValid   = 1'b1;
        @(posedge clk);
        #1;
        bus.InValid   = 1'b0;
        bus.Vrest     = $urandom;
        bus.Vmem      = {$urandom, $urandom};
        bus.DeltaT    = 4'($urandom);
        bus.Taumem    = $urandom;
        bus.ShiftMode = ~v.mode;
        bus.InTag     = ~v.tag;
        lat = 1;
        while (bus.OutValid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_res(input vec_t v, input int lat,
                             input string nm);
        chk({nm, "_lat"}, 64'(lat), 64'(v.exp_lat));
        chk({nm, "_out"}, bus.VmemOut, v.exp_out);
        chk({nm, "_tag"}, 64'(bus.OutTag), 64'(v.tag));
        chk({nm, "_dz"}, 64'(bus.DivZero), 64'(v.exp_dz));
        chk({nm, "_sat"}, 64'(bus.Sat), 64'(v.exp_sat));
    endtask

    initial begin
        int lat;
        int seen;
        total = 0;
        bad   = 0;

        vecs[0] = '{32'hFFFFFFBF, 64'hFFFFFFBA_00000000, 4'd8,
                    32'd10, 1'b0, 8'h11,
                    64'hFFFFFFBA_40000000, 1'b0, 1'b0, 67};
        vecs[1] = '{32'hFFFFFFBF, 64'hFFFFFFBA_00000000, 4'd8,
                    32'd2, 1'b1, 8'h22,
                    64'hFFFFFFBA_A0000000, 1'b0, 1'b0, 3};
        vecs[2] = '{32'h00000000, 64'h00000005_80000000, 4'd8,
                    32'd0, 1'b0, 8'h33,
                    64'h00000005_80000000, 1'b1, 1'b0, 3};
        vecs[3] = '{32'h80000001, 64'h80000000_00000000, 4'd15,
                    32'hFFFFFFFF, 1'b0, 8'h44,
                    64'h80000000_00000000, 1'b0, 1'b1, 67};
        vecs[4] = '{32'h7FFFFFFF, 64'h80000000_00000000, 4'd0,
                    32'd0, 1'b1, 8'h55,
                    64'h80000000_00000000, 1'b0, 1'b1, 3};
        vecs[5] = '{32'h00000000, 64'h0000000A_00000000, 4'd8,
                    32'd100, 1'b1, 8'h66,
                    64'h00000009_FFFFFFFF, 1'b0, 1'b0, 3};
        vecs[6] = '{32'h00000000, 64'h00000001_00000000, 4'd1,
                    32'd3, 1'b0, 8'h77,
                    64'h00000000_FAAAAAAB, 1'b0, 1'b0, 67};
        vecs[7] = '{32'h00000000, 64'h00000001_00000000, 4'd1,
                    32'd3, 1'b1, 8'h88,
                    64'h00000000_FE000000, 1'b0, 1'b0, 3};
        vecs[8] = '{32'h00000000, 64'h7FFFFFFF_00000000, 4'd8,
                    32'hFFFFFFFF, 1'b0, 8'h99,
                    64'h7FFFFFFF_FFFFFFFF, 1'b0, 1'b1, 67};
        vecs[9] = '{32'hFFFFFFBF, 64'hFFFFFFBF_00000000, 4'd15,
                    32'd7, 1'b0, 8'hAA,
                    64'hFFFFFFBF_00000000, 1'b0, 1'b0, 67};

        bus.InValid   = 1'b0;
        bus.Vrest     = '0;
        bus.Vmem      = '0;
        bus.DeltaT    = '0;
        bus.Taumem    = '0;
        bus.ShiftMode = 1'b0;
        bus.InTag     = '0;
        bus.OutReady  = 1'b1;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.OutValid), 64'd0);
        chk("rst_vout", bus.VmemOut, 64'd0);
        chk("rst_tag", 64'(bus.OutTag), 64'd0);
        chk("rst_dz", 64'(bus.DivZero), 64'd0);
        chk("rst_sat", 64'(bus.Sat), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready", 64'(bus.InReady), 64'd1);

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i], lat);
            check_res(vecs[i], lat, $sformatf("v%0d", i));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_hs", i), 64'(bus.OutValid), 64'd0);
        end

        // Backpressure: result must hold while OutReady is low.
        bus.OutReady = 1'b0;
        issue(vecs[0], lat);
        check_res(vecs[0], lat, "bp");
        for (int k = 0; k < 10; k++) begin
            bus.Vrest     = vecs[1].vrest;
            bus.Vmem      = vecs[1].vmem;
            bus.DeltaT    = vecs[1].dt;
            bus.Taumem    = vecs[1].tau;
            bus.ShiftMode = vecs[1].mode;
            bus.InTag     = vecs[1].tag;
            bus.InValid   = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_valid", 64'(bus.OutValid), 64'd1);
            chk("bp_ready", 64'(bus.InReady), 64'd0);
            chk("bp_out", bus.VmemOut, vecs[0].exp_out);
            chk("bp_tag", 64'(bus.OutTag), 64'(vecs[0].tag));
        end
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_rel_valid", 64'(bus.OutValid), 64'd0);
        chk("bp_rel_ready", 64'(bus.InReady), 64'd1);
        @(posedge clk);
        #1;
        chk("bp_no_stale", 64'(bus.InReady), 64'd1);

        // Reset in the middle of the divide.
        bus.Vrest     = vecs[0].vrest;
        bus.Vmem      = vecs[0].vmem;
        bus.DeltaT    = vecs[0].dt;
        bus.Taumem    = vecs[0].tau;
        bus.ShiftMode = vecs[0].mode;
        bus.InTag     = vecs[0].tag;
        bus.InValid   = 1'b1;
        @(posedge clk);
        #1;
        bus.InValid = 1'b0;
        chk("mid_busy", 64'(bus.InReady), 64'd0);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_async_ready", 64'(bus.InReady), 64'd1);
        chk("mid_async_valid", 64'(bus.OutValid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk);
            #1;
            if (bus.OutValid === 1'b1) seen++;
        end
        chk("mid_no_valid", 64'(seen), 64'd0);
        issue(vecs[0], lat);
        check_res(vecs[0], lat, "post_rst");
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
